warp_line_fill: RTL

Parametrised AHB5 read-burst line-fill engine; successor to the hardwired fill FSM inside warp_icache.
Fetches one cache line from memory and returns every beat with its word index. Supports critical-word-first wrap bursts, wait states and two-cycle ERROR responses.
Sits between the I/D-cache miss logic and the AHB5 manager port; read-only.

---
 rtl/warp_ahb_pkg.sv | 57 +++++
 rtl/warp_ahb_beat_addr.sv | 26 ++
 rtl/warp_line_fill.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/warp_ahb_pkg.sv
// AHB5 encodings and helpers shared by the warp line-fill engine.
// Holds HTRANS/HBURST/HRESP/HSIZE constants, the fill FSM state type and burst/size helpers.
package warp_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [3:0] HPROT_FILL = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_BURST,
    ST_DRAIN,
    ST_ERR
  } fill_state_e;

  // Fixed-length bursts only exist for 4/8/16 beats.
  function automatic logic [2:0] ahb_burst(
    input int beats,
    input bit wrap
  );
    case (beats)
      4:       return wrap ? HBURST_WRAP4 : HBURST_INCR4;
      8:       return wrap ? HBURST_WRAP8 : HBURST_INCR8;
      16:      return wrap ? HBURST_WRAP16 : HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

  function automatic logic [2:0] hsize_of(input int bytes);
    case (bytes)
      1:       return HSIZE_BYTE;
      2:       return HSIZE_HALF;
      4:       return HSIZE_WORD;
      default: return HSIZE_DWORD;
    endcase
  endfunction

endpackage

// File: rtl/warp_ahb_beat_addr.sv
// Beat address generator: maps (line base, first word, beat number) to address/word index.
// Ports: i_line_base, i_w0, i_k in; o_addr, o_idx out. Purely combinational.
module warp_ahb_beat_addr #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  localparam int BEATS     = LINE_BYTES / (DATA_W / 8),
  localparam int IW        = $clog2(BEATS)
) (
  input  logic [ADDR_W-1:0] i_line_base,
  input  logic [IW-1:0]     i_w0,
  input  logic [IW-1:0]     i_k,
  output logic [ADDR_W-1:0] o_addr,
  output logic [IW-1:0]     o_idx
);

  localparam int SZ = $clog2(DATA_W / 8);

  logic [IW-1:0] w_idx;

  // IW-bit add wraps modulo BEATS since BEATS is a power of 2.
  assign w_idx  = i_w0 + i_k;
  assign o_idx  = w_idx;
  assign o_addr = i_line_base | (ADDR_W'(w_idx) << SZ);

endmodule

// File: rtl/warp_line_fill.sv
// AHB5 read-burst line-fill engine: one request fetches one line, beats tagged by word index.
// Ports: i_req_* / o_req_ready request side, o_beat_* / o_done / o_err results, o_ahb_* / i_ahb_* manager bus.
module warp_line_fill #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int LINE_BYTES = 64,
  parameter int CRIT_FIRST = 1,
  localparam int BEATS     = LINE_BYTES / (DATA_W / 8),
  localparam int IW        = $clog2(BEATS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_beat_valid,
  output logic [IW-1:0]     o_beat_idx,
  output logic [DATA_W-1:0] o_beat_data,
  output logic              o_done,
  output logic              o_err,
  output logic [ADDR_W-1:0] o_ahb_haddr,
  output logic [2:0]        o_ahb_hburst,
  output logic [2:0]        o_ahb_hsize,
  output logic [1:0]        o_ahb_htrans,
  output logic [3:0]        o_ahb_hprot,
  output logic              o_ahb_hwrite,
  input  logic [DATA_W-1:0] i_ahb_hrdata,
  input  logic              i_ahb_hready,
  input  logic              i_ahb_hresp
);

  import warp_ahb_pkg::*;

  localparam int SZ = $clog2(DATA_W / 8);
  localparam logic [2:0] HSIZE_C  = hsize_of(DATA_W / 8);
  localparam logic [2:0] HBURST_C = ahb_burst(BEATS, CRIT_FIRST != 0);
  localparam logic [IW-1:0] LAST  = IW'(BEATS - 1);
  localparam logic [ADDR_W-1:0] LMASK = ADDR_W'(LINE_BYTES - 1);

  fill_state_e r_state, w_next;

  logic [ADDR_W-1:0] r_base;
  logic [IW-1:0]     r_w0;
  logic [IW-1:0]     r_acnt;
  logic [IW-1:0]     r_didx;
  logic              r_bvalid;
  logic [IW-1:0]     r_bidx;
  logic [DATA_W-1:0] r_bdata;
  logic              r_done;
  logic              r_err;

  logic [ADDR_W-1:0] w_addr;
  logic [IW-1:0]     w_idx;
  logic [IW-1:0]     w_req_w0;
  logic              w_accept;
  logic              w_active;
  logic              w_errc;
  logic [1:0]        w_htrans;
  logic              w_adone;
  logic              w_beat;
  logic              w_fin;
  logic              w_fail;

  warp_ahb_beat_addr #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .LINE_BYTES(LINE_BYTES)
  ) u_addr (
    .i_line_base(r_base),
    .i_w0       (r_w0),
    .i_k        (r_acnt),
    .o_addr     (w_addr),
    .o_idx      (w_idx)
  );

  assign w_accept = i_req_valid && (r_state == ST_IDLE);
  assign w_req_w0 = (CRIT_FIRST != 0) ? i_req_addr[SZ +: IW] : '0;
  assign w_errc   = (i_ahb_hresp == HRESP_ERROR);

  always_comb begin
    w_next   = r_state;
    w_htrans = HTRANS_IDLE;
    w_adone  = 1'b0;
    w_beat   = 1'b0;
    w_fin    = 1'b0;
    w_fail   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_req_valid) w_next = ST_ADDR;
      end
      ST_ADDR: begin
        // No data phase in flight yet, so HRESP is not ours.
        w_htrans = HTRANS_NONSEQ;
        if (i_ahb_hready) begin
          w_adone = 1'b1;
          w_next  = ST_BURST;
        end
      end
      ST_BURST: begin
        w_htrans = HTRANS_SEQ;
        if (w_errc) begin
          if (i_ahb_hready) begin
            w_fail = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_next = ST_ERR;
          end
        end else if (i_ahb_hready) begin
          w_adone = 1'b1;
          w_beat  = 1'b1;
          if (r_acnt == LAST) w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_errc) begin
          if (i_ahb_hready) begin
            w_fail = 1'b1;
            w_next = ST_IDLE;
          end else begin
            w_next = ST_ERR;
          end
        end else if (i_ahb_hready) begin
          w_beat = 1'b1;
          w_fin  = 1'b1;
          w_next = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (i_ahb_hready) begin
          w_fail = 1'b1;
          w_next = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_base   <= '0;
      r_w0     <= '0;
      r_acnt   <= '0;
      r_didx   <= '0;
      r_bvalid <= 1'b0;
      r_bidx   <= '0;
      r_bdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_bvalid <= w_beat;
      r_done   <= w_fin | w_fail;
      r_err    <= w_fail;
      if (w_accept) begin
        r_base <= i_req_addr & ~LMASK;
        r_w0   <= w_req_w0;
        r_acnt <= '0;
      end
      // Data phase of the address just completed carries this index.
      if (w_adone) begin
        r_acnt <= r_acnt + 1'b1;
        r_didx <= w_idx;
      end
      if (w_beat) begin
        r_bidx  <= r_didx;
        r_bdata <= i_ahb_hrdata;
      end
    end
  end

  assign w_active = (r_state == ST_ADDR) || (r_state == ST_BURST);

  assign o_req_ready  = (r_state == ST_IDLE);
  assign o_beat_valid = r_bvalid;
  assign o_beat_idx   = r_bidx;
  assign o_beat_data  = r_bdata;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_ahb_haddr  = w_active ? w_addr : '0;
  assign o_ahb_hburst = w_active ? HBURST_C : 3'b000;
  assign o_ahb_hsize  = HSIZE_C;
  assign o_ahb_htrans = w_htrans;
  assign o_ahb_hprot  = HPROT_FILL;
  assign o_ahb_hwrite = 1'b0;

endmodule
